// File: rtl/fmcropping.sv
// rtl/fmcropping.sv - feature-map cropping: forwards the [XON,XOFF)x[YON,YOFF) window of a stream frame
module fmcropping #(
  parameter int XCOUNTER_BITS = 8,
  parameter int YCOUNTER_BITS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int SIMD          = 2,
  parameter int ELEM_BITS     = 8,
  parameter int INIT_XON      = 1,
  parameter int INIT_XOFF     = 5,
  parameter int INIT_XEND     = 5,
  parameter int INIT_YON      = 1,
  parameter int INIT_YOFF     = 5,
  parameter int INIT_YEND     = 5,
  localparam int STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   we,
  input  logic [2:0]             wa,
  input  logic [31:0]            wd,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [STREAM_BITS-1:0] s_axis_tdata,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [STREAM_BITS-1:0] m_axis_tdata
);

  localparam int XB      = XCOUNTER_BITS;
  localparam int YB      = YCOUNTER_BITS;
  localparam int CF      = NUM_CHANNELS / SIMD;
  localparam int CF_BITS = (CF > 1) ? $clog2(CF) : 1;

  logic [XB-1:0] st_xon, st_xoff, st_xend, nx_xon, nx_xoff, nx_xend;
  logic [YB-1:0] st_yon, st_yoff, st_yend, nx_yon, nx_yoff, nx_yend;
  logic [XB-1:0] a_xon, a_xoff, a_xend, x;
  logic [YB-1:0] a_yon, a_yoff, a_yend, y;
  logic [CF_BITS-1:0] cf;
  logic keep, acc, load, ovld;
  logic [STREAM_BITS-1:0] odat;
  logic unused_wd;

  assign unused_wd = ^wd;

  // Staging values as they will be after this cycle's write; a boundary load uses these
  always_comb begin
    nx_xon  = st_xon;
    nx_xoff = st_xoff;
    nx_xend = st_xend;
    nx_yon  = st_yon;
    nx_yoff = st_yoff;
    nx_yend = st_yend;
    if (we) begin
      case (wa)
        3'd0: nx_xon  = wd[XB-1:0];
        3'd1: nx_xoff = wd[XB-1:0];
        3'd2: nx_xend = wd[XB-1:0];
        3'd3: nx_yon  = wd[YB-1:0];
        3'd4: nx_yoff = wd[YB-1:0];
        3'd5: nx_yend = wd[YB-1:0];
        default: ;
      endcase
    end
  end

  assign keep          = (x >= a_xon) && (x < a_xoff) && (y >= a_yon) && (y < a_yoff);
  assign s_axis_tready = !keep || !ovld || m_axis_tready;
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign load          = (cf == '0) && (x == '0) && (y == '0) && !acc;
  assign m_axis_tvalid = ovld;
  assign m_axis_tdata  = odat;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      st_xon  <= XB'(INIT_XON);
      st_xoff <= XB'(INIT_XOFF);
      st_xend <= XB'(INIT_XEND);
      st_yon  <= YB'(INIT_YON);
      st_yoff <= YB'(INIT_YOFF);
      st_yend <= YB'(INIT_YEND);
      a_xon   <= XB'(INIT_XON);
      a_xoff  <= XB'(INIT_XOFF);
      a_xend  <= XB'(INIT_XEND);
      a_yon   <= YB'(INIT_YON);
      a_yoff  <= YB'(INIT_YOFF);
      a_yend  <= YB'(INIT_YEND);
    end else begin
      st_xon  <= nx_xon;
      st_xoff <= nx_xoff;
      st_xend <= nx_xend;
      st_yon  <= nx_yon;
      st_yoff <= nx_yoff;
      st_yend <= nx_yend;
      if (load) begin
        a_xon  <= nx_xon;
        a_xoff <= nx_xoff;
        a_xend <= nx_xend;
        a_yon  <= nx_yon;
        a_yoff <= nx_yoff;
        a_yend <= nx_yend;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cf <= '0;
      x  <= '0;
      y  <= '0;
    end else if (acc) begin
      if (cf == CF_BITS'(CF - 1)) begin
        cf <= '0;
        if (x == a_xend) begin
          x <= '0;
          y <= (y == a_yend) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else begin
        cf <= cf + 1'b1;
      end
    end
  end

  // Drain and load in the same cycle keeps ovld high so kept beats stream without bubbles
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovld <= 1'b0;
      odat <= '0;
    end else if (acc && keep) begin
      ovld <= 1'b1;
      odat <= s_axis_tdata;
    end else if (m_axis_tready) begin
      ovld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmcropping.sv
// tb/tb_fmcropping.sv - self-checking bench for fmcropping against a frame-geometry model
module tb_fmcropping;

  localparam int CF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we;
  logic [2:0]  wa;
  logic [31:0] wd;
  logic        s_ready, s_valid, m_ready, m_valid;
  logic [15:0] s_data, m_data;

  always #5 clk = ~clk;

  fmcropping dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .s_axis_tready(s_ready), .s_axis_tvalid(s_valid), .s_axis_tdata(s_data),
    .m_axis_tready(m_ready), .m_axis_tvalid(m_valid), .m_axis_tdata(m_data)
  );

  int checks = 0;
  int errors = 0;
  int st[6];
  int act[6];
  int pos;
  int out_cnt;
  logic [15:0] q[$];
  bit          exp_pend;
  logic [15:0] exp_data;
  logic [15:0] first_d, last_d;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic void init_model();
    st  = '{1, 5, 5, 1, 5, 5};
    act = '{1, 5, 5, 1, 5, 5};
  endfunction

  function automatic int frame_len();
    return CF * (act[2] + 1) * (act[5] + 1);
  endfunction

  // Beat p of a frame is pixel p/CF in raster order over a (XEND+1)-wide image
  function automatic bit keep_at(input int p);
    int pix, w, px, py;
    pix = p / CF;
    w   = act[2] + 1;
    px  = pix % w;
    py  = pix / w;
    return (px >= act[0]) && (px < act[1]) && (py >= act[3]) && (py < act[4]);
  endfunction

  initial init_model();

  always @(negedge clk) begin : monitor
    bit acc, k;
    logic [15:0] e;
    if (!rst_n) begin
      chk("rst_tvalid", {31'd0, m_valid}, 0);
      chk("rst_tdata", {16'd0, m_data}, 0);
      q.delete();
      pos = 0;
      exp_pend = 0;
      init_model();
    end else begin
      acc = s_valid && s_ready;
      k = keep_at(pos);
      if (exp_pend) begin
        chk("latency_valid", {31'd0, m_valid}, 1);
        chk("latency_data", {16'd0, m_data}, {16'd0, exp_data});
      end
      exp_pend = 0;
      chk("s_ready", {31'd0, s_ready}, {31'd0, (!k || !m_valid || m_ready)});
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {16'd0, m_data}, 32'hffff_ffff);
        end else begin
          e = q.pop_front();
          chk("out_data", {16'd0, m_data}, {16'd0, e});
          if (out_cnt == 0) first_d = m_data;
          last_d = m_data;
          out_cnt++;
        end
      end
      if (we && wa < 3'd6) st[wa] = int'(wd);
      if (acc) begin
        if (k) begin
          q.push_back(s_data);
          exp_pend = 1;
          exp_data = s_data;
        end
        pos++;
        if (pos >= frame_len()) pos = 0;
      end else if (pos == 0) begin
        act = st;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int tag, input int n, input int wr_beat, input logic [2:0] a,
                           input logic [31:0] d, input bit tog, input bit clr, input bit idle);
    int i;
    int budget;
    bit acc, wdone;
    i = 0; budget = 0; wdone = 0;
    if (clr) out_cnt = 0;
    while (i < n) begin
      s_valid = 1'b1;
      s_data  = {tag[7:0], i[7:0]};
      if (i == wr_beat && !wdone) begin
        we = 1'b1; wa = a; wd = d;
      end
      if (tog) m_ready = ~m_ready;
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      if (we) wdone = 1;
      we = 1'b0;
      if (acc) i++;
      budget++;
      if (budget > 1000) begin
        chk("frame_budget", budget, 0);
        break;
      end
    end
    if (idle) s_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!m_valid) done = 1;
    end
    chk("drain_done", {31'd0, done}, 1);
    @(posedge clk); #1;
    chk("drain_queue", q.size(), 0);
  endtask

  task automatic frame_chk(input string name, input int n, input int f, input int l);
    chk({name, "_count"}, out_cnt, n);
    if (n > 0) begin
      chk({name, "_first"}, {24'd0, first_d[7:0]}, f);
      chk({name, "_last"}, {24'd0, last_d[7:0]}, l);
    end
  endtask

  initial begin
    we = 0; wa = 0; wd = 0; s_valid = 0; s_data = 0; m_ready = 1;
    out_cnt = 0; first_d = 0; last_d = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_s_ready", {31'd0, s_ready}, 1);
    chk("reset_m_valid", {31'd0, m_valid}, 0);
    @(posedge clk); #1;

    run_frame(1, 72, -1, 0, 0, 0, 1, 1);
    drain();
    frame_chk("default", 32, 14, 57);

    run_frame(2, 72, -1, 0, 0, 1, 1, 1);
    drain();
    frame_chk("toggle", 32, 14, 57);

    run_frame(3, 72, 20, 3'd0, 0, 0, 1, 1);
    drain();
    frame_chk("midwrite_cur", 32, 14, 57);
    run_frame(4, 72, -1, 0, 0, 0, 1, 1);
    drain();
    frame_chk("midwrite_next", 40, 12, 57);
    wr(3'd0, 1);

    wr(3'd1, 2);
    wr(3'd0, 3);
    wr(3'd6, 0);
    run_frame(5, 72, -1, 0, 0, 0, 1, 1);
    drain();
    frame_chk("empty", 0, 0, 0);
    wr(3'd0, 1);
    wr(3'd1, 5);
    run_frame(6, 72, -1, 0, 0, 0, 1, 1);
    drain();
    frame_chk("restored", 32, 14, 57);

    run_frame(7, 30, -1, 0, 0, 0, 1, 1);
    m_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("held_valid", {31'd0, m_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, m_valid}, 0);
    chk("async_data", {16'd0, m_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    chk("post_rst_ready", {31'd0, s_ready}, 1);
    run_frame(8, 72, -1, 0, 0, 0, 1, 1);
    drain();
    frame_chk("after_reset", 32, 14, 57);

    run_frame(9, 72, 5, 3'd0, 0, 0, 1, 0);
    run_frame(10, 72, -1, 0, 0, 0, 0, 1);
    drain();
    frame_chk("b2b", 64, 14, 57);
    chk("b2b_first_tag", {24'd0, first_d[15:8]}, 9);
    chk("b2b_last_tag", {24'd0, last_d[15:8]}, 10);
    run_frame(11, 72, -1, 0, 0, 0, 1, 1);
    drain();
    frame_chk("after_b2b", 40, 12, 57);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
